// File: rtl/rvfi_seq_pkg.sv
// Shared types and payload layout for the RVFI retirement serializer.
// Payload field offsets are derived from XLEN/ILEN so every user agrees on packing.
package rvfi_seq_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_ILEN = 32;

  function automatic int off_insn(input int xlen, input int ilen);
    return 0 * xlen + 0 * ilen;
  endfunction

  function automatic int off_trap(input int ilen);
    return ilen;
  endfunction

  function automatic int off_halt(input int ilen);
    return ilen + 1;
  endfunction

  function automatic int off_intr(input int ilen);
    return ilen + 2;
  endfunction

  function automatic int off_mode(input int ilen);
    return ilen + 3;
  endfunction

  function automatic int off_ixl(input int ilen);
    return ilen + 5;
  endfunction

  function automatic int off_rs1_addr(input int ilen);
    return ilen + 7;
  endfunction

  function automatic int off_rs2_addr(input int ilen);
    return ilen + 12;
  endfunction

  function automatic int off_rs1_rdata(input int ilen);
    return ilen + 17;
  endfunction

  function automatic int off_rs2_rdata(input int xlen, input int ilen);
    return ilen + 17 + xlen;
  endfunction

  function automatic int off_rd_addr(input int xlen, input int ilen);
    return ilen + 17 + 2 * xlen;
  endfunction

  function automatic int off_rd_wdata(input int xlen, input int ilen);
    return ilen + 22 + 2 * xlen;
  endfunction

  function automatic int off_pc_rdata(input int xlen, input int ilen);
    return ilen + 22 + 3 * xlen;
  endfunction

  function automatic int off_pc_wdata(input int xlen, input int ilen);
    return ilen + 22 + 4 * xlen;
  endfunction

  function automatic int off_mem_addr(input int xlen, input int ilen);
    return ilen + 22 + 5 * xlen;
  endfunction

  function automatic int off_mem_rmask(input int xlen, input int ilen);
    return ilen + 22 + 6 * xlen;
  endfunction

  function automatic int off_mem_wmask(input int xlen, input int ilen);
    return ilen + 22 + 6 * xlen + xlen / 8;
  endfunction

  function automatic int off_mem_rdata(input int xlen, input int ilen);
    return ilen + 22 + 6 * xlen + xlen / 4;
  endfunction

  function automatic int off_mem_wdata(input int xlen, input int ilen);
    return ilen + 22 + 7 * xlen + xlen / 4;
  endfunction

  function automatic int pw_f(input int xlen, input int ilen);
    return ilen + 22 + 8 * xlen + xlen / 4;
  endfunction

  localparam int DEF_PW = pw_f(DEF_XLEN, DEF_ILEN);

  typedef struct packed {
    logic [63:0]       order;
    logic [DEF_PW-1:0] payload;
  } entry_t;

  function automatic int popcount(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      r += int'(v[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/rvfi_seq_fifo.sv
// Circular buffer: up to NRET writes per cycle, one read per cycle.
// Caller guarantees writes never exceed free space.
module rvfi_seq_fifo #(
  parameter  int NRET  = 1,
  parameter  int W     = 64,
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(NRET + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [CW-1:0]              wr_cnt,
  input  logic [NRET-1:0][W-1:0]     wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [LW-1:0]              level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      for (int i = 0; i < NRET; i++) begin
        if (i < int'(wr_cnt)) begin
          mem_d[(int'(wr_ptr_q) + i) % DEPTH] = wr_data[i];
        end
      end
      wr_ptr_d = AW'((int'(wr_ptr_q) + int'(wr_cnt)) % DEPTH);
    end
    if (rd_en) begin
      rd_ptr_d = AW'((int'(rd_ptr_q) + 1) % DEPTH);
    end
    level_d = LW'(int'(level_q)
                  + (wr_en ? int'(wr_cnt) : 0)
                  - (rd_en ? 1 : 0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: only slots below level are ever observed.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/rvfi_seq_serializer.sv
// Serializes an NRET-wide RVFI retire bus into one retirement per cycle,
// checking program order and flagging dropped groups.
module rvfi_seq_serializer
  import rvfi_seq_pkg::*;
#(
  parameter  int NRET  = 1,
  parameter  int XLEN  = 32,
  parameter  int ILEN  = 32,
  parameter  int DEPTH = 8,
  localparam int PW    = pw_f(XLEN, ILEN),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NRET-1:0]    in_valid,
  input  logic [NRET*64-1:0] in_order,
  input  logic [NRET*PW-1:0] in_payload,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_order,
  output logic [PW-1:0]      out_payload,
  output logic [LW-1:0]      level,
  output logic               err_order,
  output logic               err_overflow
);

  localparam int W  = 64 + PW;
  localparam int CW = $clog2(NRET + 1);

  logic [NRET-1:0][W-1:0] wr_data;
  logic [CW-1:0]          wr_cnt;
  logic                   wr_en;
  logic                   pop;
  logic [W-1:0]           head;
  int                     n;
  int                     space;
  int                     rank;

  logic        exp_valid_q, exp_valid_d;
  logic [63:0] exp_q, exp_d;
  logic        err_order_q, err_order_d;
  logic        err_ovf_q, err_ovf_d;

  // Valid channels packed into the lowest free slots, channel order kept.
  always_comb begin
    wr_data = '0;
    for (int c = 0; c < NRET; c++) begin
      rank = 0;
      for (int j = 0; j < c; j++) begin
        rank += int'(in_valid[j]);
      end
      if (in_valid[c]) begin
        for (int s = 0; s < NRET; s++) begin
          if (s == rank) begin
            wr_data[s] = {in_order[c*64 +: 64], in_payload[c*PW +: PW]};
          end
        end
      end
    end
  end

  always_comb begin
    n      = popcount(32'(in_valid));
    space  = DEPTH - int'(level);
    wr_en  = (n != 0) && (n <= space);
    wr_cnt = CW'(n);
  end

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;

  rvfi_seq_fifo #(
    .NRET  (NRET),
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level)
  );

  assign out_order   = out_valid ? head[W-1 -: 64] : '0;
  assign out_payload = out_valid ? head[PW-1:0]    : '0;

  // Expected order always follows the last popped entry, so a gap flags once.
  always_comb begin
    exp_valid_d = exp_valid_q;
    exp_d       = exp_q;
    err_order_d = err_order_q;
    err_ovf_d   = err_ovf_q;
    if (pop) begin
      if (exp_valid_q && (out_order != exp_q)) begin
        err_order_d = 1'b1;
      end
      exp_d       = out_order + 64'd1;
      exp_valid_d = 1'b1;
    end
    if ((n != 0) && !wr_en) begin
      err_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      exp_valid_q <= 1'b0;
      exp_q       <= '0;
      err_order_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      exp_valid_q <= exp_valid_d;
      exp_q       <= exp_d;
      err_order_q <= err_order_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign err_order    = err_order_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_rvfi_seq_serializer.sv
// Directed and random checks of rvfi_seq_serializer (NRET=2, DEPTH=8)
// against a queue-based model of the retirement stream.
module tb_rvfi_seq_serializer;
  import rvfi_seq_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 8;
  localparam int PW    = pw_f(32, 32);
  localparam int LW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [NRET-1:0]    in_valid;
  logic [NRET*64-1:0] in_order;
  logic [NRET*PW-1:0] in_payload;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        out_order;
  logic [PW-1:0]      out_payload;
  logic [LW-1:0]      level;
  logic               err_order;
  logic               err_overflow;

  int n_chk  = 0;
  int n_fail = 0;

  entry_t      mq[$];
  logic        m_err_o;
  logic        m_err_ov;
  logic        m_ev;
  logic [63:0] m_exp;
  logic [63:0] ord_ctr;

  always #5 clk = ~clk;

  rvfi_seq_serializer #(
    .NRET  (NRET),
    .XLEN  (32),
    .ILEN  (32),
    .DEPTH (DEPTH)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_order     (in_order),
    .in_payload   (in_payload),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_order    (out_order),
    .out_payload  (out_payload),
    .level        (level),
    .err_order    (err_order),
    .err_overflow (err_overflow)
  );

  task automatic chk(input string tag,
                     input logic [PW+63:0] obs,
                     input logic [PW+63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [63:0] ord);
    logic [319:0] p;
    for (int i = 0; i < 10; i++) p[i*32 +: 32] = $urandom;
    in_order[c*64 +: 64]   = ord;
    in_payload[c*PW +: PW] = p[PW-1:0];
  endtask

  task automatic model_edge();
    int   lvl;
    int   n;
    entry_t h;
    if (reset) begin
      mq.delete();
      m_err_o  = 1'b0;
      m_err_ov = 1'b0;
      m_ev     = 1'b0;
      m_exp    = '0;
    end else begin
      lvl = mq.size();
      n   = 0;
      for (int c = 0; c < NRET; c++) n += int'(in_valid[c]);
      if (lvl > 0 && out_ready) begin
        h = mq.pop_front();
        if (m_ev && h.order != m_exp) m_err_o = 1'b1;
        m_exp = h.order + 64'd1;
        m_ev  = 1'b1;
      end
      if (n > 0) begin
        if (n <= DEPTH - lvl) begin
          for (int c = 0; c < NRET; c++) begin
            if (in_valid[c]) begin
              h.order   = in_order[c*64 +: 64];
              h.payload = in_payload[c*PW +: PW];
              mq.push_back(h);
            end
          end
        end else begin
          m_err_ov = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", (PW+64)'(out_valid), (PW+64)'(mq.size() != 0));
    chk("level", (PW+64)'(level), (PW+64)'(mq.size()));
    chk("err_order", (PW+64)'(err_order), (PW+64)'(m_err_o));
    chk("err_overflow", (PW+64)'(err_overflow), (PW+64)'(m_err_ov));
    if (mq.size() != 0) begin
      chk("out_order", (PW+64)'(out_order), (PW+64)'(mq[0].order));
      chk("out_payload", (PW+64)'(out_payload), (PW+64)'(mq[0].payload));
    end else begin
      chk("out_order_idle", (PW+64)'(out_order), '0);
      chk("out_payload_idle", (PW+64)'(out_payload), '0);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    in_valid = '1;
    set_ch(0, 64'd77);
    set_ch(1, 64'd78);
    for (int i = 0; i < cycles; i++) step();
    reset    = 1'b0;
    in_valid = '0;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = '1;
    in_order   = '0;
    in_payload = '0;
    out_ready  = 1'b1;
    m_err_o    = 1'b0;
    m_err_ov   = 1'b0;
    m_ev       = 1'b0;
    m_exp      = '0;
    ord_ctr    = '0;

    // Reset held with all channels valid
    do_reset(3);
    chk("rst_level", (PW+64)'(level), '0);
    chk("rst_out_valid", (PW+64)'(out_valid), '0);

    // Two-wide group, orders 10 and 11
    in_valid = 2'b11;
    set_ch(0, 64'd10);
    set_ch(1, 64'd11);
    step();
    chk("grp_first", (PW+64)'(out_order), (PW+64)'(64'd10));
    in_valid = 2'b00;
    step();
    chk("grp_second", (PW+64)'(out_order), (PW+64)'(64'd11));
    step();
    chk("grp_drained", (PW+64)'(out_valid), '0);
    chk("grp_err_order", (PW+64)'(err_order), '0);

    // Channel 1 alone compacts to slot 0
    do_reset(1);
    in_valid = 2'b10;
    set_ch(0, 64'd99);
    set_ch(1, 64'd5);
    step();
    chk("compact_order", (PW+64)'(out_order), (PW+64)'(64'd5));
    chk("compact_level", (PW+64)'(level), (PW+64)'(1));
    in_valid = 2'b00;
    step();

    // Fill to DEPTH with no consumer, then overflow one group
    do_reset(1);
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      in_valid = 2'b11;
      set_ch(0, 64'(2 * g));
      set_ch(1, 64'(2 * g + 1));
      step();
      if (g == 3) chk("full_level", (PW+64)'(level), (PW+64)'(8));
    end
    chk("ovf_level", (PW+64)'(level), (PW+64)'(8));
    chk("ovf_flag", (PW+64)'(err_overflow), (PW+64)'(1));
    in_valid  = 2'b00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", (PW+64)'(out_order), (PW+64)'(64'(i)));
      step();
    end
    chk("drain_level", (PW+64)'(level), '0);
    chk("drain_err_order", (PW+64)'(err_order), '0);

    // Order gap: 0,1,3,4
    do_reset(1);
    out_ready = 1'b1;
    in_valid  = 2'b01;
    set_ch(0, 64'd0);
    step();
    set_ch(0, 64'd1);
    step();
    set_ch(0, 64'd3);
    step();
    chk("gap_before", (PW+64)'(err_order), '0);
    set_ch(0, 64'd4);
    step();
    chk("gap_flag", (PW+64)'(err_order), (PW+64)'(1));
    in_valid = 2'b00;
    step();
    chk("gap_sticky", (PW+64)'(err_order), (PW+64)'(1));

    // Reset with entries queued, then a fresh base order
    do_reset(1);
    out_ready = 1'b0;
    in_valid  = 2'b11;
    set_ch(0, 64'd40);
    set_ch(1, 64'd41);
    step();
    set_ch(0, 64'd42);
    set_ch(1, 64'd43);
    step();
    chk("mid_level", (PW+64)'(level), (PW+64)'(4));
    do_reset(1);
    chk("mid_rst_level", (PW+64)'(level), '0);
    chk("mid_rst_valid", (PW+64)'(out_valid), '0);
    out_ready = 1'b1;
    in_valid  = 2'b01;
    set_ch(0, 64'd100);
    step();
    in_valid = 2'b00;
    step();
    chk("base_no_err", (PW+64)'(err_order), '0);

    // Random traffic with occasional gaps, stalls and resets
    do_reset(1);
    ord_ctr = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = NRET'($urandom);
      for (int c = 0; c < NRET; c++) begin
        if ($urandom_range(0, 31) == 0) ord_ctr = ord_ctr + 64'd2;
        set_ch(c, ord_ctr);
        if (in_valid[c]) ord_ctr = ord_ctr + 64'd1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
